pic_ctrl_logic_n: RTL and testbench

Parametrised, clocked control-logic core for the PIC 8259 project, generalised to `NUM_IR` interrupt inputs. It holds the IRR, ISR and IMR registers and resolves priority in fixed or rotating mode. It runs the two-pulse interrupt-acknowledge handshake and produces the vector byte, and it executes ICW/OCW commands decoded upstream by the read/write logic. It sits between the data-bus buffer/RW decoder and the cascade/bus-output logic.

---
 rtl/pic_pkg.sv | 29 ++
 rtl/pic_priority_resolver.sv | 51 +++++
 rtl/pic_ctrl_logic_n.sv | 233 +++++++++++++++++++++++
 tb/tb_pic_ctrl_logic_n.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared encodings for the PIC control-logic core: OCW2 commands, OCW3 read
// selects, handshake FSM states and the index-width helper.
package pic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK1 = 2'd1,
    ST_WAIT_ACK2 = 2'd2
  } pic_state_e;

  typedef enum logic [2:0] {
    OCW2_ROT_AEOI_CLR = 3'b000,
    OCW2_NS_EOI       = 3'b001,
    OCW2_NOP          = 3'b010,
    OCW2_SP_EOI       = 3'b011,
    OCW2_ROT_AEOI_SET = 3'b100,
    OCW2_ROT_NS_EOI   = 3'b101,
    OCW2_SET_PRI      = 3'b110,
    OCW2_ROT_SP_EOI   = 3'b111
  } ocw2_cmd_e;

  localparam logic [1:0] RD_SEL_IRR = 2'b10;
  localparam logic [1:0] RD_SEL_ISR = 2'b11;

  function automatic int idx_w(input int num_ir);
    return (num_ir <= 2) ? 1 : $clog2(num_ir);
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating-priority resolver: highest pending request and highest in-service
// level, both counted from (lowest + 1), plus the fully-nested compare.
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter  int NUM_IR = 8,
  localparam int IDX_W  = idx_w(NUM_IR)
) (
  input  logic [NUM_IR-1:0] req,
  input  logic [NUM_IR-1:0] isr,
  input  logic [IDX_W-1:0]  lowest,
  output logic              req_valid,
  output logic [IDX_W-1:0]  req_idx,
  output logic              isr_valid,
  output logic [IDX_W-1:0]  isr_idx,
  output logic              req_outranks
);

  logic [IDX_W-1:0] pos;
  logic [IDX_W-1:0] req_rank;
  logic [IDX_W-1:0] isr_rank;

  // NOTE: every output and temporary gets a default before the loop so no
  // path through this block leaves a value held, which would infer a latch.
  always_comb begin
    req_valid = 1'b0;
    req_idx   = '0;
    req_rank  = '0;
    isr_valid = 1'b0;
    isr_idx   = '0;
    isr_rank  = '0;
    pos       = '0;
    // Scan from lowest rank upward so the last hit is the highest priority;
    // rank k maps to level (lowest + 1 + k) mod NUM_IR via index wrap-around.
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      pos = lowest + IDX_W'(k + 1);
      if (req[pos]) begin
        req_valid = 1'b1;
        req_idx   = pos;
        req_rank  = IDX_W'(k);
      end
      if (isr[pos]) begin
        isr_valid = 1'b1;
        isr_idx   = pos;
        isr_rank  = IDX_W'(k);
      end
    end
    req_outranks = !isr_valid || (req_rank < isr_rank);
  end

endmodule

// File: rtl/pic_ctrl_logic_n.sv
// PIC 8259-style control core: IRR/ISR/IMR, command execution and the
// two-pulse INTA handshake that emits base|index on vec_out.
module pic_ctrl_logic_n
  import pic_pkg::*;
#(
  parameter int NUM_IR = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_icw1,
  input  logic              wr_icw2,
  input  logic              wr_icw4,
  input  logic              wr_ocw1,
  input  logic              wr_ocw2,
  input  logic              wr_ocw3,
  input  logic [NUM_IR-1:0] ir_in,
  input  logic              ack_n,
  output logic              int_out,
  output logic              vec_valid,
  output logic [DATA_W-1:0] vec_out,
  output logic [NUM_IR-1:0] reg_out,
  output logic [NUM_IR-1:0] imr_out
);

  localparam int IDX_W = idx_w(NUM_IR);

  pic_state_e        state_q, state_d;
  logic              ltim_q, ltim_d;
  logic              aeoi_q, aeoi_d;
  logic              rot_aeoi_q, rot_aeoi_d;
  logic              rd_isr_q, rd_isr_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  lowest_q, lowest_d;
  logic [NUM_IR-1:0] irr_q, irr_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [NUM_IR-1:0] imr_q, imr_d;
  logic [NUM_IR-1:0] ir_prev_q, ir_prev_d;
  logic              ack_prev_q, ack_prev_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic              grant_real_q, grant_real_d;
  logic              int_q, int_d;
  logic              vec_valid_q, vec_valid_d;
  logic [DATA_W-1:0] vec_q, vec_d;

  logic              req_valid, isr_valid, req_outranks;
  logic [IDX_W-1:0]  req_idx, isr_idx;
  logic [NUM_IR-1:0] ocw1_mask;
  logic              do_icw1, do_icw2, do_icw4, do_ocw1, do_ocw2, do_ocw3;
  logic              ack_fall;
  logic [IDX_W-1:0]  lvl;
  ocw2_cmd_e         ocw2_cmd;

  if (NUM_IR <= DATA_W) begin : g_imr_narrow
    assign ocw1_mask = data_in[NUM_IR-1:0];
  end else begin : g_imr_wide
    assign ocw1_mask = {{(NUM_IR - DATA_W){1'b0}}, data_in};
  end

  // Only the highest-precedence strobe of a cycle executes.
  assign do_icw1 = wr_icw1;
  assign do_icw2 = wr_icw2 & ~wr_icw1;
  assign do_icw4 = wr_icw4 & ~(wr_icw1 | wr_icw2);
  assign do_ocw1 = wr_ocw1 & ~(wr_icw1 | wr_icw2 | wr_icw4);
  assign do_ocw2 = wr_ocw2 & ~(wr_icw1 | wr_icw2 | wr_icw4 | wr_ocw1);
  assign do_ocw3 = wr_ocw3 & ~(wr_icw1 | wr_icw2 | wr_icw4 | wr_ocw1 | wr_ocw2);

  assign ack_fall = ~ack_n & ack_prev_q;
  assign lvl      = data_in[IDX_W-1:0];
  assign ocw2_cmd = ocw2_cmd_e'(data_in[7:5]);

  pic_priority_resolver #(.NUM_IR(NUM_IR)) u_resolver (
    .req          (irr_q & ~imr_q),
    .isr          (isr_q),
    .lowest       (lowest_q),
    .req_valid    (req_valid),
    .req_idx      (req_idx),
    .isr_valid    (isr_valid),
    .isr_idx      (isr_idx),
    .req_outranks (req_outranks)
  );

  always_comb begin
    state_d      = state_q;
    ltim_d       = ltim_q;
    aeoi_d       = aeoi_q;
    rot_aeoi_d   = rot_aeoi_q;
    rd_isr_d     = rd_isr_q;
    base_d       = base_q;
    lowest_d     = lowest_q;
    isr_d        = isr_q;
    imr_d        = imr_q;
    grant_idx_d  = grant_idx_q;
    grant_real_d = grant_real_q;
    int_d        = int_q;
    vec_valid_d  = 1'b0;
    vec_d        = '0;
    ir_prev_d    = ir_in;
    ack_prev_d   = ack_n;
    irr_d        = ltim_q ? ir_in : (irr_q | (ir_in & ~ir_prev_q));

    if (do_icw2) base_d = {data_in[DATA_W-1:IDX_W], {IDX_W{1'b0}}};
    if (do_icw4) aeoi_d = data_in[1];
    if (do_ocw1) imr_d = ocw1_mask;
    if (do_ocw3) begin
      if (data_in[1:0] == RD_SEL_IRR) rd_isr_d = 1'b0;
      if (data_in[1:0] == RD_SEL_ISR) rd_isr_d = 1'b1;
    end

    // EOIs act on the registered ISR, ahead of any grant set below.
    if (do_ocw2) begin
      case (ocw2_cmd)
        OCW2_NS_EOI:       if (isr_valid) isr_d[isr_idx] = 1'b0;
        OCW2_SP_EOI:       isr_d[lvl] = 1'b0;
        OCW2_ROT_NS_EOI: begin
          if (isr_valid) begin
            isr_d[isr_idx] = 1'b0;
            lowest_d       = isr_idx;
          end
        end
        OCW2_ROT_SP_EOI: begin
          isr_d[lvl] = 1'b0;
          lowest_d   = lvl;
        end
        OCW2_ROT_AEOI_SET: rot_aeoi_d = 1'b1;
        OCW2_ROT_AEOI_CLR: rot_aeoi_d = 1'b0;
        OCW2_SET_PRI:      lowest_d = lvl;
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_outranks) begin
          state_d = ST_WAIT_ACK1;
          int_d   = 1'b1;
        end
      end
      ST_WAIT_ACK1: begin
        if (ack_fall) begin
          state_d = ST_WAIT_ACK2;
          if (req_valid && req_outranks) begin
            grant_idx_d    = req_idx;
            grant_real_d   = 1'b1;
            isr_d[req_idx] = 1'b1;
            irr_d[req_idx] = 1'b0;
          end else begin
            grant_idx_d  = IDX_W'(NUM_IR - 1);
            grant_real_d = 1'b0;
          end
        end
      end
      ST_WAIT_ACK2: begin
        if (ack_fall) begin
          state_d     = ST_IDLE;
          int_d       = 1'b0;
          vec_valid_d = 1'b1;
          vec_d       = base_q | DATA_W'(grant_idx_q);
          if (aeoi_q && grant_real_q) begin
            isr_d[grant_idx_q] = 1'b0;
            if (rot_aeoi_q) lowest_d = grant_idx_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_icw1) begin
      ltim_d      = data_in[3];
      irr_d       = '0;
      isr_d       = '0;
      imr_d       = '0;
      lowest_d    = IDX_W'(NUM_IR - 1);
      rot_aeoi_d  = 1'b0;
      aeoi_d      = 1'b0;
      rd_isr_d    = 1'b0;
      state_d     = ST_IDLE;
      int_d       = 1'b0;
      vec_valid_d = 1'b0;
      vec_d       = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ltim_q       <= 1'b0;
      aeoi_q       <= 1'b0;
      rot_aeoi_q   <= 1'b0;
      rd_isr_q     <= 1'b0;
      base_q       <= '0;
      lowest_q     <= IDX_W'(NUM_IR - 1);
      irr_q        <= '0;
      isr_q        <= '0;
      imr_q        <= '0;
      ir_prev_q    <= '0;
      ack_prev_q   <= 1'b1;
      grant_idx_q  <= '0;
      grant_real_q <= 1'b0;
      int_q        <= 1'b0;
      vec_valid_q  <= 1'b0;
      vec_q        <= '0;
    end else begin
      state_q      <= state_d;
      ltim_q       <= ltim_d;
      aeoi_q       <= aeoi_d;
      rot_aeoi_q   <= rot_aeoi_d;
      rd_isr_q     <= rd_isr_d;
      base_q       <= base_d;
      lowest_q     <= lowest_d;
      irr_q        <= irr_d;
      isr_q        <= isr_d;
      imr_q        <= imr_d;
      ir_prev_q    <= ir_prev_d;
      ack_prev_q   <= ack_prev_d;
      grant_idx_q  <= grant_idx_d;
      grant_real_q <= grant_real_d;
      int_q        <= int_d;
      vec_valid_q  <= vec_valid_d;
      vec_q        <= vec_d;
    end
  end

  assign int_out   = int_q;
  assign vec_valid = vec_valid_q;
  assign vec_out   = vec_q;
  assign reg_out   = rd_isr_q ? isr_q : irr_q;
  assign imr_out   = imr_q;

endmodule

// File: tb/tb_pic_ctrl_logic_n.sv
// Scoreboarded bench for pic_ctrl_logic_n: directed handshake scenarios plus a
// randomized level-mode run against a rank-based priority model.
module tb_pic_ctrl_logic_n;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int W_ICW1 = 0, W_ICW2 = 1, W_ICW4 = 2, W_OCW1 = 3, W_OCW2 = 4, W_OCW3 = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          wr_icw1 = 0, wr_icw2 = 0, wr_icw4 = 0, wr_ocw1 = 0, wr_ocw2 = 0, wr_ocw3 = 0;
  logic [N-1:0]  ir_in = '0;
  logic          ack_n = 1'b1;
  logic          int_out, vec_valid;
  logic [DW-1:0] vec_out;
  logic [N-1:0]  reg_out, imr_out;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  // Reference model state (level mode, transaction-level).
  logic [N-1:0] m_ir, m_imr, m_isr;
  int           m_lowest;

  pic_ctrl_logic_n #(.NUM_IR(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .wr_icw1(wr_icw1), .wr_icw2(wr_icw2), .wr_icw4(wr_icw4),
    .wr_ocw1(wr_ocw1), .wr_ocw2(wr_ocw2), .wr_ocw3(wr_ocw3),
    .ir_in(ir_in), .ack_n(ack_n), .int_out(int_out), .vec_valid(vec_valid),
    .vec_out(vec_out), .reg_out(reg_out), .imr_out(imr_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every vector pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && vec_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vec: got 0x%0h, required no vector", vec_out);
      end else begin
        check("vec_out", 32'(vec_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int which, input logic [7:0] d);
    data_in = d;
    case (which)
      W_ICW1:  wr_icw1 = 1'b1;
      W_ICW2:  wr_icw2 = 1'b1;
      W_ICW4:  wr_icw4 = 1'b1;
      W_OCW1:  wr_ocw1 = 1'b1;
      W_OCW2:  wr_ocw2 = 1'b1;
      default: wr_ocw3 = 1'b1;
    endcase
    tick();
    {wr_icw1, wr_icw2, wr_icw4, wr_ocw1, wr_ocw2, wr_ocw3} = '0;
  endtask

  task automatic ack_edge();
    ack_n = 1'b0;
    tick();
    ack_n = 1'b1;
    tick();
  endtask

  task automatic init(input logic [7:0] icw1, input logic [7:0] icw4);
    ir_in = '0;
    tick();
    wr(W_ICW1, icw1);
    wr(W_ICW2, 8'hA8);
    wr(W_ICW4, icw4);
    wr(W_OCW1, 8'h00);
  endtask

  task automatic wait_int(input string name);
    int c = 0;
    while (int_out !== 1'b1 && c < 12) begin
      tick();
      c++;
    end
    check(name, 32'(int_out), 32'd1);
  endtask

  function automatic int rank(input int i);
    return (i - m_lowest - 1 + 2 * N) % N;
  endfunction

  function automatic int pick(input logic [N-1:0] v);
    int best = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && (best < 0 || rank(i) < rank(best))) best = i;
    return best;
  endfunction

  function automatic int m_req();
    int p = pick(m_ir & ~m_imr);
    int q = pick(m_isr);
    if (p < 0) return -1;
    if (q >= 0 && rank(p) >= rank(q)) return -1;
    return p;
  endfunction

  initial begin
    int q, l, g, guard;

    // Reset state
    tick(2);
    check("rst_int", 32'(int_out), 0);
    check("rst_vec_valid", 32'(vec_valid), 0);
    check("rst_vec_out", 32'(vec_out), 0);
    check("rst_reg_out", 32'(reg_out), 0);
    check("rst_imr_out", 32'(imr_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Level mode, nested, request latency
    init(8'h0B, 8'h01);
    ir_in = 8'h02;
    tick();
    check("lat_irr", 32'(reg_out), 32'h02);
    check("lat_int_early", 32'(int_out), 0);
    tick();
    check("lat_int", 32'(int_out), 1);
    exp_q.push_back(8'hA9);
    ack_edge();
    ack_edge();
    check("lvl_int_after_ack2", 32'(int_out), 0);
    wr(W_OCW3, 8'h0B);
    check("lvl_isr", 32'(reg_out), 32'h02);
    ir_in = '0;
    wr(W_OCW2, 8'h20);
    check("lvl_isr_eoi", 32'(reg_out), 0);

    // AEOI
    init(8'h0B, 8'h03);
    ir_in = 8'h02;
    wait_int("aeoi_int");
    ack_edge();
    ir_in = '0;
    exp_q.push_back(8'hA9);
    ack_edge();
    wr(W_OCW3, 8'h0B);
    check("aeoi_isr", 32'(reg_out), 0);
    check("aeoi_int", 32'(int_out), 0);

    // Nesting
    init(8'h0B, 8'h01);
    ir_in = 8'h20;
    wait_int("nest_int5");
    exp_q.push_back(8'hAD);
    ack_edge();
    ack_edge();
    ir_in = 8'h24;
    wait_int("nest_int2");
    exp_q.push_back(8'hAA);
    ack_edge();
    ack_edge();
    wr(W_OCW3, 8'h0B);
    check("nest_isr", 32'(reg_out), 32'h24);
    ir_in = '0;
    wr(W_OCW2, 8'h20);
    check("nest_eoi_first", 32'(reg_out), 32'h20);
    wr(W_OCW2, 8'h20);

    // Masking
    init(8'h0B, 8'h01);
    wr(W_OCW1, 8'h02);
    ir_in = 8'h02;
    tick(4);
    check("mask_int", 32'(int_out), 0);
    check("mask_imr", 32'(imr_out), 32'h02);
    wr(W_OCW1, 8'h00);
    check("unmask_int_same", 32'(int_out), 0);
    tick();
    check("unmask_int", 32'(int_out), 1);
    exp_q.push_back(8'hA9);
    ack_edge();
    ack_edge();

    // Rotation
    init(8'h0B, 8'h01);
    wr(W_OCW2, 8'hC3);
    ir_in = 8'h14;
    wait_int("rot_int4");
    exp_q.push_back(8'hAC);
    ack_edge();
    ack_edge();
    tick(3);
    check("rot_ir2_blocked", 32'(int_out), 0);
    wr(W_OCW3, 8'h0B);
    check("rot_isr4", 32'(reg_out), 32'h10);
    wr(W_OCW2, 8'hA0);
    wait_int("rot_int2");
    exp_q.push_back(8'hAA);
    ack_edge();
    ack_edge();
    check("rot_isr2", 32'(reg_out), 32'h04);
    ir_in = '0;
    wr(W_OCW2, 8'h20);
    ir_in = 8'h30;
    wait_int("rot_int5");
    exp_q.push_back(8'hAD);
    ack_edge();
    ack_edge();
    ir_in = '0;

    // Spurious
    init(8'h0B, 8'h01);
    ir_in = 8'h02;
    wait_int("spur_int");
    ir_in = '0;
    tick(2);
    exp_q.push_back(8'hAF);
    ack_edge();
    ack_edge();
    wr(W_OCW3, 8'h0B);
    check("spur_isr", 32'(reg_out), 0);

    // Edge mode
    init(8'h03, 8'h01);
    ir_in = 8'h08;
    wait_int("edge_int");
    exp_q.push_back(8'hAB);
    ack_edge();
    ack_edge();
    check("edge_irr_clear", 32'(reg_out), 0);
    wr(W_OCW3, 8'h0B);
    check("edge_isr", 32'(reg_out), 32'h08);
    wr(W_OCW2, 8'h20);
    tick(3);
    check("edge_no_retrigger", 32'(int_out), 0);
    ir_in = '0;
    tick();
    ir_in = 8'h08;
    wait_int("edge_retrigger");
    exp_q.push_back(8'hAB);
    ack_edge();
    ack_edge();
    ir_in = '0;

    // ICW1 aborts a handshake; ACKs in IDLE are ignored
    init(8'h0B, 8'h01);
    ir_in = 8'h02;
    wait_int("abort_int");
    ack_edge();
    ir_in = '0;
    wr(W_ICW1, 8'h0B);
    check("abort_int_low", 32'(int_out), 0);
    ack_edge();
    tick(2);
    wr(W_OCW3, 8'h0B);
    check("abort_isr", 32'(reg_out), 0);

    // Strobe precedence: ICW2 beats a simultaneous OCW1
    data_in = 8'h55;
    wr_icw2 = 1'b1;
    wr_ocw1 = 1'b1;
    tick();
    {wr_icw2, wr_ocw1} = '0;
    check("precedence_imr", 32'(imr_out), 0);

    // Randomized level-mode run
    init(8'h0B, 8'h01);
    wr(W_OCW3, 8'h0B);
    m_ir = '0; m_imr = '0; m_isr = '0; m_lowest = N - 1;
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 6))
        0: begin m_ir = N'($urandom); ir_in = m_ir; end
        1: begin m_imr = N'($urandom & $urandom); wr(W_OCW1, m_imr); end
        2: begin
          q = pick(m_isr);
          if (q >= 0) m_isr[q] = 1'b0;
          wr(W_OCW2, 8'h20);
        end
        3: begin
          l = $urandom_range(0, N - 1);
          m_isr[l] = 1'b0;
          wr(W_OCW2, 8'h60 | 8'(l));
        end
        4: begin
          q = pick(m_isr);
          if (q >= 0) begin m_isr[q] = 1'b0; m_lowest = q; end
          wr(W_OCW2, 8'hA0);
        end
        5: begin
          l = $urandom_range(0, N - 1);
          m_isr[l] = 1'b0;
          m_lowest = l;
          wr(W_OCW2, 8'hE0 | 8'(l));
        end
        default: begin
          l = $urandom_range(0, N - 1);
          m_lowest = l;
          wr(W_OCW2, 8'hC0 | 8'(l));
        end
      endcase
      tick(3);
      g = m_req();
      check("rnd_int", 32'(int_out), 32'(g >= 0));
      guard = 0;
      while (g >= 0 && guard < N + 2) begin
        ack_edge();
        m_isr[g] = 1'b1;
        exp_q.push_back(8'hA8 | 8'(g));
        ack_edge();
        tick(2);
        g = m_req();
        guard++;
      end
      check("rnd_int_settled", 32'(int_out), 32'(g >= 0));
      check("rnd_isr", 32'(reg_out), 32'(m_isr));
      check("rnd_imr", 32'(imr_out), 32'(m_imr));
    end
    ir_in = '0;

    // Asynchronous reset in WAIT_ACK2
    init(8'h0B, 8'h01);
    wr(W_OCW1, 8'h80);
    wr(W_OCW3, 8'h0B);
    ir_in = 8'h02;
    wait_int("arst_int");
    ack_edge();
    check("arst_pre_isr", 32'(reg_out), 32'h02);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_int", 32'(int_out), 0);
    check("arst_vec_valid", 32'(vec_valid), 0);
    check("arst_vec_out", 32'(vec_out), 0);
    check("arst_reg_out", 32'(reg_out), 0);
    check("arst_imr_out", 32'(imr_out), 0);
    ir_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    check("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
